// File: rtl/biu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// biu_pkg : shared encodings for the L1-side bus interface units
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package biu_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LINE = 3'd1;
   localparam logic [2:0] ST_SRD  = 3'd2;
   localparam logic [2:0] ST_SWR  = 3'd3;
   localparam logic [2:0] ST_FIN  = 3'd4;

   localparam logic [3:0] SZ_B = 4'b0001;
   localparam logic [3:0] SZ_H = 4'b0010;
   localparam logic [3:0] SZ_W = 4'b0100;
   localparam logic [3:0] SZ_D = 4'b1000;

   localparam int BEAT_BYTES = 8;

   function automatic int line_off_w(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

endpackage
`default_nettype wire

// File: rtl/biu_beat_timeout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// biu_beat_timeout : per-beat ack watchdog, restarted for every bus beat
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module biu_beat_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic ack,
   output logic expire
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic          running_q, running_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Kept independent of start so the caller may restart in the same cycle.
   assign expire = running_q && !ack && (TIMEOUT != 0) && (cnt_q == LAST);

   always_comb begin
      running_d = running_q;
      cnt_d     = cnt_q;
      if (start) begin
         running_d = 1'b1;
         cnt_d     = '0;
      end else if (running_q) begin
         if (ack || expire) running_d = 1'b0;
         else               cnt_d     = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         running_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         running_q <= running_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/l1_bus_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l1_bus_responder : turns L1 refill / uncached read / write-through requests
//                    into 64-bit req/ack bus beats and returns the results
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module l1_bus_responder
   import biu_pkg::*;
#(
   parameter int LINE_BYTES = 1024,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read_line_req,
   input  logic        read_req,
   input  logic        write_through_req,
   input  logic [3:0]  L1_size,
   input  logic [63:0] pa,
   input  logic [63:0] wt_data,
   output logic [63:0] line_data,
   output logic [10:0] addr_count,
   output logic        line_write,
   output logic        cache_entry_refill,
   output logic        trans_rdy,
   output logic        bus_error,
   output logic        bus_req,
   output logic        bus_we,
   output logic [63:0] bus_addr,
   output logic [3:0]  bus_size,
   output logic [63:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [63:0] bus_rdata,
   input  logic        bus_err
);

   localparam int OFF_W = line_off_w(LINE_BYTES);
   localparam int BW    = OFF_W - 3;
   localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BYTES / BEAT_BYTES - 1);

   logic [2:0]    state_q, state_d;
   logic [63:0]   base_q, base_d;
   logic [BW-1:0] beat_q, beat_d;
   logic          refill_pend_q, refill_pend_d;
   logic [63:0]   line_data_q, line_data_d;
   logic [10:0]   addr_count_q, addr_count_d;
   logic          line_write_q, line_write_d;
   logic          refill_q, refill_d;
   logic          trans_rdy_q, trans_rdy_d;
   logic          bus_error_q, bus_error_d;
   logic          bus_req_q, bus_req_d;
   logic          bus_we_q, bus_we_d;
   logic [63:0]   bus_addr_q, bus_addr_d;
   logic [3:0]    bus_size_q, bus_size_d;
   logic [63:0]   bus_wdata_q, bus_wdata_d;

   logic          tmo_start, tmo_expire;
   logic          beat_ack, beat_end, beat_fail;
   logic [BW-1:0] next_beat;

   biu_beat_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .start  (tmo_start),
      .ack    (beat_ack),
      .expire (tmo_expire)
   );

   assign beat_ack  = bus_req_q && bus_ack;
   assign beat_end  = beat_ack || tmo_expire;
   assign beat_fail = (beat_ack && bus_err) || tmo_expire;
   assign next_beat = beat_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      beat_d        = beat_q;
      refill_pend_d = refill_pend_q;
      line_data_d   = line_data_q;
      addr_count_d  = addr_count_q;
      line_write_d  = 1'b0;
      refill_d      = 1'b0;
      trans_rdy_d   = 1'b0;
      bus_error_d   = 1'b0;
      bus_req_d     = bus_req_q;
      bus_we_d      = bus_we_q;
      bus_addr_d    = bus_addr_q;
      bus_size_d    = bus_size_q;
      bus_wdata_d   = bus_wdata_q;
      tmo_start     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (read_line_req) begin
               state_d    = ST_LINE;
               base_d     = {pa[63:OFF_W], {OFF_W{1'b0}}};
               beat_d     = '0;
               bus_addr_d = {pa[63:OFF_W], {OFF_W{1'b0}}};
               bus_size_d = SZ_D;
               bus_we_d   = 1'b0;
               bus_req_d  = 1'b1;
               tmo_start  = 1'b1;
            end else if (read_req || write_through_req) begin
               state_d    = read_req ? ST_SRD : ST_SWR;
               bus_addr_d = pa;
               bus_size_d = L1_size;
               bus_we_d   = !read_req;
               bus_req_d  = 1'b1;
               tmo_start  = 1'b1;
               if (!read_req) bus_wdata_d = wt_data;
            end
         end
         ST_LINE: begin
            if (refill_pend_q) begin
               refill_pend_d = 1'b0;
               refill_d      = 1'b1;
               trans_rdy_d   = 1'b1;
               state_d       = ST_FIN;
            end else if (beat_end) begin
               if (beat_fail) begin
                  bus_req_d   = 1'b0;
                  bus_error_d = 1'b1;
                  state_d     = ST_FIN;
               end else begin
                  line_write_d = 1'b1;
                  line_data_d  = bus_rdata;
                  addr_count_d = 11'({beat_q, 3'b000});
                  if (beat_q == LAST_BEAT) begin
                     bus_req_d     = 1'b0;
                     refill_pend_d = 1'b1;
                  end else begin
                     // Next beat goes out while this one is being written back.
                     beat_d     = next_beat;
                     bus_addr_d = base_q | 64'({next_beat, 3'b000});
                     tmo_start  = 1'b1;
                  end
               end
            end
         end
         ST_SRD, ST_SWR: begin
            if (beat_end) begin
               bus_req_d = 1'b0;
               state_d   = ST_FIN;
               if (beat_fail) begin
                  bus_error_d = 1'b1;
               end else begin
                  trans_rdy_d = 1'b1;
                  if (state_q == ST_SRD) line_data_d = bus_rdata;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         base_q        <= '0;
         beat_q        <= '0;
         refill_pend_q <= 1'b0;
         line_data_q   <= '0;
         addr_count_q  <= '0;
         line_write_q  <= 1'b0;
         refill_q      <= 1'b0;
         trans_rdy_q   <= 1'b0;
         bus_error_q   <= 1'b0;
         bus_req_q     <= 1'b0;
         bus_we_q      <= 1'b0;
         bus_addr_q    <= '0;
         bus_size_q    <= '0;
         bus_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         beat_q        <= beat_d;
         refill_pend_q <= refill_pend_d;
         line_data_q   <= line_data_d;
         addr_count_q  <= addr_count_d;
         line_write_q  <= line_write_d;
         refill_q      <= refill_d;
         trans_rdy_q   <= trans_rdy_d;
         bus_error_q   <= bus_error_d;
         bus_req_q     <= bus_req_d;
         bus_we_q      <= bus_we_d;
         bus_addr_q    <= bus_addr_d;
         bus_size_q    <= bus_size_d;
         bus_wdata_q   <= bus_wdata_d;
      end
   end

   assign line_data          = line_data_q;
   assign addr_count         = addr_count_q;
   assign line_write         = line_write_q;
   assign cache_entry_refill = refill_q;
   assign trans_rdy          = trans_rdy_q;
   assign bus_error          = bus_error_q;
   assign bus_req            = bus_req_q;
   assign bus_we             = bus_we_q;
   assign bus_addr           = bus_addr_q;
   assign bus_size           = bus_size_q;
   assign bus_wdata          = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_bus_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_l1_bus_responder : directed self-checking bench for l1_bus_responder
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_l1_bus_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        read_line_req = 1'b0, read_req = 1'b0, write_through_req = 1'b0;
   logic [3:0]  L1_size = 4'b0;
   logic [63:0] pa = 64'h0, wt_data = 64'h0;
   logic        bus_ack = 1'b0, bus_err = 1'b0;
   logic [63:0] bus_rdata = 64'h0;
   logic        t_line_req = 1'b0;

   logic [63:0] line_data, bus_addr, bus_wdata;
   logic [10:0] addr_count;
   logic [3:0]  bus_size;
   logic        line_write, cache_entry_refill, trans_rdy, bus_error, bus_req, bus_we;

   logic [63:0] t_line_data, t_bus_addr, t_bus_wdata;
   logic [10:0] t_addr_count;
   logic [3:0]  t_bus_size;
   logic        t_line_write, t_refill, t_trans_rdy, t_bus_error, t_bus_req, t_bus_we;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   l1_bus_responder #(.LINE_BYTES(64), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .read_line_req(read_line_req), .read_req(read_req), .write_through_req(write_through_req),
      .L1_size(L1_size), .pa(pa), .wt_data(wt_data),
      .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
      .cache_entry_refill(cache_entry_refill), .trans_rdy(trans_rdy), .bus_error(bus_error),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_size(bus_size),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   // Second instance with a short watchdog and a bus that never answers.
   l1_bus_responder #(.LINE_BYTES(64), .TIMEOUT(4)) dut_t (
      .clk(clk), .rst(rst),
      .read_line_req(t_line_req), .read_req(1'b0), .write_through_req(1'b0),
      .L1_size(L1_size), .pa(pa), .wt_data(wt_data),
      .line_data(t_line_data), .addr_count(t_addr_count), .line_write(t_line_write),
      .cache_entry_refill(t_refill), .trans_rdy(t_trans_rdy), .bus_error(t_bus_error),
      .bus_req(t_bus_req), .bus_we(t_bus_we), .bus_addr(t_bus_addr), .bus_size(t_bus_size),
      .bus_wdata(t_bus_wdata), .bus_ack(1'b0), .bus_rdata(64'h0), .bus_err(1'b0)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " line_data"},  line_data, 64'h0);
      chk({tag, " addr_count"}, 64'(addr_count), 64'h0);
      chk({tag, " strobes"}, {60'h0, line_write, cache_entry_refill, trans_rdy, bus_error}, 64'h0);
      chk({tag, " bus_req"},  64'(bus_req), 64'h0);
      chk({tag, " bus_we"},   64'(bus_we), 64'h0);
      chk({tag, " bus_addr"}, bus_addr, 64'h0);
      chk({tag, " bus_size"}, 64'(bus_size), 64'h0);
      chk({tag, " bus_wdata"}, bus_wdata, 64'h0);
   endtask

   initial begin
      // ---------------- reset state ----------------
      step();
      step();
      chk_all_zero("reset");
      chk("reset t_bus_req", 64'(t_bus_req), 64'h0);
      rst = 1'b0;
      step();
      chk("post-reset bus_req", 64'(bus_req), 64'h0);

      // ---------------- line refill, 8 beats, ack after 2 cycles ----------------
      read_line_req = 1'b1;
      pa = 64'h1000_0234;
      step();
      read_line_req = 1'b0;
      for (int b = 0; b < 8; b++) begin
         chk($sformatf("line b%0d bus_req", b), 64'(bus_req), 64'h1);
         chk($sformatf("line b%0d bus_addr", b), bus_addr, 64'h1000_0200 + 64'(8 * b));
         chk($sformatf("line b%0d bus_size/we", b), {59'h0, bus_size, bus_we}, {59'h0, 4'b1000, 1'b0});
         step();
         chk($sformatf("line b%0d hold", b), {62'h0, bus_req, line_write}, {62'h0, 1'b1, 1'b0});
         step();
         bus_ack   = 1'b1;
         bus_rdata = 64'(b);
         step();
         bus_ack   = 1'b0;
         chk($sformatf("line b%0d line_write", b), 64'(line_write), 64'h1);
         chk($sformatf("line b%0d addr_count", b), 64'(addr_count), 64'(8 * b));
         chk($sformatf("line b%0d line_data", b), line_data, 64'(b));
         chk($sformatf("line b%0d refill/rdy", b), {62'h0, cache_entry_refill, trans_rdy}, 64'h0);
      end
      chk("line last bus_req", 64'(bus_req), 64'h0);
      step();
      chk("line refill/rdy", {61'h0, cache_entry_refill, trans_rdy, line_write}, {61'h0, 3'b110});
      step();
      chk("line after", {61'h0, cache_entry_refill, trans_rdy, bus_req}, 64'h0);

      // ---------------- uncached 4-byte read ----------------
      read_req = 1'b1;
      L1_size  = 4'b0100;
      pa       = 64'h8000_0004;
      step();
      read_req = 1'b0;
      chk("srd bus_req", 64'(bus_req), 64'h1);
      chk("srd bus_addr", bus_addr, 64'h8000_0004);
      chk("srd bus_size/we", {59'h0, bus_size, bus_we}, {59'h0, 4'b0100, 1'b0});
      bus_ack   = 1'b1;
      bus_rdata = 64'hDEAD_BEEF;
      step();
      bus_ack = 1'b0;
      chk("srd trans_rdy", 64'(trans_rdy), 64'h1);
      chk("srd line_data", line_data, 64'hDEAD_BEEF);
      chk("srd line_write", 64'(line_write), 64'h0);
      chk("srd bus_req drop", 64'(bus_req), 64'h0);
      step();
      chk("srd after", {62'h0, trans_rdy, line_write}, 64'h0);

      // ---------------- write-through, ack after 5 cycles, request held ----------------
      write_through_req = 1'b1;
      L1_size = 4'b1000;
      pa      = 64'h2000_0008;
      wt_data = 64'h1122_3344_5566_7788;
      step();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("swr c%0d req/we", i), {62'h0, bus_req, bus_we}, {62'h0, 2'b11});
         chk($sformatf("swr c%0d wdata", i), bus_wdata, 64'h1122_3344_5566_7788);
         chk($sformatf("swr c%0d trans_rdy", i), 64'(trans_rdy), 64'h0);
         if (i == 4) bus_ack = 1'b1;
         step();
      end
      bus_ack = 1'b0;
      chk("swr bus_addr", bus_addr, 64'h2000_0008);
      chk("swr trans_rdy", 64'(trans_rdy), 64'h1);
      chk("swr bus_req drop", 64'(bus_req), 64'h0);
      step();
      chk("swr fin ignores req", {62'h0, bus_req, trans_rdy}, 64'h0);
      step();
      chk("swr reaccept", 64'(bus_req), 64'h1);
      write_through_req = 1'b0;
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      chk("swr2 trans_rdy", 64'(trans_rdy), 64'h1);
      step();
      step();

      // ---------------- line refill with bus_err on beat 3 ----------------
      read_line_req = 1'b1;
      pa = 64'h0000_4040;
      step();
      read_line_req = 1'b0;
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("err b%0d bus_addr", b), bus_addr, 64'h4040 + 64'(8 * b));
         bus_ack   = 1'b1;
         bus_err   = (b == 3);
         bus_rdata = 64'hA0 + 64'(b);
         step();
         bus_ack = 1'b0;
         bus_err = 1'b0;
         if (b < 3) begin
            chk($sformatf("err b%0d line_write", b), 64'(line_write), 64'h1);
            chk($sformatf("err b%0d line_data", b), line_data, 64'hA0 + 64'(b));
         end
      end
      chk("err strobe", {60'h0, bus_error, line_write, trans_rdy, cache_entry_refill}, {60'h0, 4'b1000});
      chk("err bus_req", 64'(bus_req), 64'h0);
      read_req = 1'b1;
      L1_size  = 4'b0001;
      pa       = 64'h0000_0011;
      step();
      chk("err idle timing", {62'h0, bus_req, bus_error}, 64'h0);
      step();
      read_req = 1'b0;
      chk("err back in idle", 64'(bus_req), 64'h1);
      chk("err next addr", bus_addr, 64'h11);
      bus_ack   = 1'b1;
      bus_rdata = 64'h77;
      step();
      bus_ack = 1'b0;
      chk("err next rdy", {63'h0, trans_rdy}, 64'h1);
      step();
      step();

      // ---------------- timeout, TIMEOUT=4, bus never acks ----------------
      t_line_req = 1'b1;
      pa = 64'h0000_9000;
      step();
      t_line_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("tmo c%0d req/err", i), {62'h0, t_bus_req, t_bus_error}, {62'h0, 2'b10});
         step();
      end
      chk("tmo drop/err", {61'h0, t_bus_req, t_bus_error, t_line_write}, {61'h0, 3'b010});
      chk("tmo rdy/refill", {62'h0, t_trans_rdy, t_refill}, 64'h0);
      step();
      chk("tmo err one cycle", {62'h0, t_bus_error, t_bus_req}, 64'h0);

      // ---------------- reset during a line refill ----------------
      read_line_req = 1'b1;
      pa = 64'h3000_0000;
      step();
      read_line_req = 1'b0;
      bus_ack   = 1'b1;
      bus_rdata = 64'h55;
      step();
      chk("rst-mid beat0 line_write", 64'(line_write), 64'h1);
      rst = 1'b1;
      step();
      chk_all_zero("rst-mid");
      rst     = 1'b0;
      bus_ack = 1'b0;
      step();
      chk("rst-mid quiet1", {59'h0, bus_req, line_write, cache_entry_refill, trans_rdy, bus_error}, 64'h0);
      step();
      chk("rst-mid quiet2", {59'h0, bus_req, line_write, cache_entry_refill, trans_rdy, bus_error}, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/l1_bus_responder.md
Name: l1_bus_responder

Overview:
- BIU-side cache controller answering the L1 data cache's request channel: line refills, uncached single reads and write-through writes.
- Converts each request into beats on the core's simple 64-bit request/acknowledge memory bus.
- Returns data through the refill-stream signals (line_data, addr_count, line_write, cache_entry_refill), with trans_rdy/bus_error as completion.
- Sits between the L1 and the system bus arbiter.

Parameters:
- LINE_BYTES, 1024, bytes per cache line; power of two, 16..2048; beats = LINE_BYTES/8.
- TIMEOUT, 255, max cycles a beat waits for bus_ack before it is treated as a bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- read_line_req  in  1  L1 requests a line refill
- read_req  in  1  L1 requests a single uncached read
- write_through_req  in  1  L1 requests a single write
- L1_size  in  4  access size, one-hot: 0001=1B, 0010=2B, 0100=4B, 1000=8B
- pa  in  64  physical address
- wt_data  in  64  write data
- line_data  out  64  returned read data (refill beat or single read)
- addr_count  out  11  byte offset within the line of the current line_data beat
- line_write  out  1  one-cycle strobe: line_data/addr_count are valid for the L1 array write
- cache_entry_refill  out  1  one-cycle strobe: line complete, tag may be updated
- trans_rdy  out  1  one-cycle completion strobe
- bus_error  out  1  one-cycle failure strobe
- bus_req  out  1  beat request to the bus
- bus_we  out  1  1 = write beat
- bus_addr  out  64  beat address
- bus_size  out  4  beat size, same encoding as L1_size
- bus_wdata  out  64  write data
- bus_ack  in  1  beat accepted/completed
- bus_rdata  in  64  read data, valid with bus_ack
- bus_err  in  1  beat failed, valid with bus_ack

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset mid-transaction aborts it; no trans_rdy, bus_error or refill pulse is emitted, and bus_req is 0 the cycle after reset.
- States: IDLE, LINE, SRD, SWR, FIN.
- IDLE: samples requests with priority read_line_req > read_req > write_through_req.
  - On a request, latch pa, L1_size and wt_data.
  - LINE: base = pa with its low log2(LINE_BYTES) bits cleared; beat counter = 0.
  - Next state is LINE, SRD or SWR. bus_req rises the cycle after the request is seen.
- Bus rule: bus_req, bus_we, bus_addr, bus_size and bus_wdata stay stable until the cycle bus_ack=1. bus_req drops the cycle after the ack unless another beat follows. At most one beat is outstanding.
- LINE beat:
  - bus_addr = base + 8*beat; bus_size = 1000; bus_we = 0.
  - On ack with bus_err=0, the next cycle shows line_data = bus_rdata, addr_count = 8*beat and line_write = 1 for exactly one cycle; the beat counter then increments.
  - The next beat's bus_req re-asserts in the same cycle as that line_write (back-to-back allowed).
  - After the last beat's line_write, the following cycle pulses cache_entry_refill and trans_rdy together, then the state goes to FIN.
- SRD: bus_addr = latched pa, bus_size = latched size. On good ack, the next cycle shows line_data = bus_rdata and trans_rdy = 1 together. line_write stays 0. State goes to FIN.
- SWR: bus_we = 1, bus_wdata = wt_data. On good ack, the next cycle pulses trans_rdy. State goes to FIN.
- Error: ack with bus_err=1, or timeout expiry, in any transfer state:
  - The next cycle pulses bus_error, with trans_rdy, line_write and cache_entry_refill all 0.
  - Remaining line beats are abandoned and the state goes to FIN.
- Timeout: a counter clears when each beat's bus_req first asserts and counts while bus_ack=0. When it reaches TIMEOUT it ends the beat as an error and drops bus_req.
- FIN: one idle cycle with requests ignored, so the L1 can leave its request state, then IDLE.
- Request lines are ignored outside IDLE. Dropping a request mid-transfer does not abort it.
- Outside its strobe cycle, line_data holds its last value. addr_count holds its value and wraps naturally at LINE_BYTES.

Decomposition:
- Shared package (biu_pkg): state encoding, size one-hot constants (SZ_B/H/W/D), BEAT_BYTES=8, a line-offset-width function.
- One natural sub-module: biu_beat_timeout. It is the cycle counter with start, ack and expire ports, parameterised by TIMEOUT, and is reusable by the instruction-fetch BIU.

Test Plan:
- LINE_BYTES=64, read_line_req with pa=0x1000_0234, bus acks each beat after 2 cycles with rdata=beat index -> bus_addr 0x1000_0200..0x1000_0238 step 8; 8 line_write pulses with addr_count 0..56 and line_data 0..7; then one cycle with cache_entry_refill and trans_rdy together, both 0 otherwise.
- read_req, L1_size=0100, pa=0x8000_0004, ack rdata=0xDEAD_BEEF -> bus_size=0100, bus_addr=0x8000_0004; next cycle trans_rdy=1 and line_data=0xDEAD_BEEF; line_write stays 0.
- write_through_req, wt_data=0x1122334455667788, ack after 5 cycles -> bus_we=1 with bus_wdata held 5 cycles; one trans_rdy; next request is not accepted until after the FIN cycle.
- Line refill with bus_err on beat 3 -> exactly 3 line_write pulses, then one bus_error pulse; no cache_entry_refill or trans_rdy; back in IDLE 2 cycles later.
- TIMEOUT=4, bus_ack never asserted -> bus_req high 4 cycles then low; bus_error pulse next cycle. Separately, assert rst during a line refill -> all outputs 0 on the next cycle, with no strobes.
